// File: rtl/event_timestamp_capture.sv
// event_timestamp_capture
// Timestamps rising edges of i_event with the free-running i_counter value
// and queues them in a first-word-fall-through FIFO drained over valid/ready.
// The head entry is held in its own output register, so o_timestamp is
// registered and holds stable while the consumer stalls.

module event_timestamp_capture #(
   parameter int COUNTER_WIDTH = 16,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic [COUNTER_WIDTH-1:0]      i_counter,
   input  logic                          i_event,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [COUNTER_WIDTH-1:0]      o_timestamp,
   output logic [$clog2(FIFO_DEPTH):0]   o_level,
   output logic                          o_overflow,
   input  logic                          i_clear_overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(FIFO_DEPTH);

   // Registered state
   logic                     event_q_r;
   logic [PTR_W-1:0]         rd_ptr_r;
   logic [PTR_W-1:0]         wr_ptr_r;
   logic [LVL_W-1:0]         level_r;
   logic                     valid_r;
   logic                     overflow_r;
   logic [COUNTER_WIDTH-1:0] timestamp_r;
   logic [COUNTER_WIDTH-1:0] mem_r [FIFO_DEPTH];

   // Combinational decisions for the current edge
   logic                     event_s;
   logic                     pop_s;
   logic                     full_s;
   logic                     push_s;
   logic                     drop_s;
   logic [PTR_W-1:0]         rd_inc_s;
   logic [LVL_W-1:0]         level_next_s;
   logic [COUNTER_WIDTH-1:0] head_next_s;
   logic                     overflow_next_s;

   // Edge detect and push/pop/drop arbitration; full comes from the level count.
   always_comb begin
      event_s  = i_event & ~event_q_r;
      pop_s    = valid_r & i_ready;
      full_s   = (level_r == LEVEL_FULL);
      push_s   = event_s & (~full_s | pop_s);
      drop_s   = event_s & full_s & ~pop_s;
      rd_inc_s = rd_ptr_r + PTR_W'(1);
   end

   // Next occupancy: a simultaneous push and pop leaves the level unchanged.
   always_comb begin
      level_next_s = level_r;
      case ({push_s, pop_s})
         2'b10:   level_next_s = level_r + LVL_W'(1);
         2'b01:   level_next_s = level_r - LVL_W'(1);
         default: level_next_s = level_r;
      endcase
   end

   // Next head value: the entry behind the popped one, or a bypassed capture
   // when that slot is being written at this very edge.
   always_comb begin
      head_next_s = timestamp_r;
      if (pop_s) begin
         if (push_s && (rd_inc_s == wr_ptr_r)) begin
            head_next_s = i_counter;
         end else begin
            head_next_s = mem_r[rd_inc_s];
         end
      end else if (push_s && !valid_r) begin
         head_next_s = i_counter;
      end else begin
         head_next_s = timestamp_r;
      end
   end

   // Sticky overflow: a drop at the same edge as a clear keeps the flag set.
   always_comb begin
      overflow_next_s = overflow_r;
      if (drop_s) begin
         overflow_next_s = 1'b1;
      end else if (i_clear_overflow) begin
         overflow_next_s = 1'b0;
      end else begin
         overflow_next_s = overflow_r;
      end
   end

   // Control and output registers with synchronous active-low reset.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         event_q_r   <= 1'b1;
         rd_ptr_r    <= '0;
         wr_ptr_r    <= '0;
         level_r     <= '0;
         valid_r     <= 1'b0;
         overflow_r  <= 1'b0;
         timestamp_r <= '0;
      end else begin
         event_q_r   <= i_event;
         level_r     <= level_next_s;
         valid_r     <= (level_next_s != LVL_W'(0));
         overflow_r  <= overflow_next_s;
         timestamp_r <= head_next_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_inc_s;
         end
      end
   end

   // Timestamp storage; contents are not reset, only the pointers are.
   always_ff @(posedge i_clock) begin
      if (push_s && i_reset) begin
         mem_r[wr_ptr_r] <= i_counter;
      end
   end

   assign o_valid     = valid_r;
   assign o_level     = level_r;
   assign o_overflow  = overflow_r;
   assign o_timestamp = timestamp_r;

endmodule

// File: tb/tb_event_timestamp_capture.sv
// Testbench for event_timestamp_capture: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.

module tb_event_timestamp_capture;

   localparam int CW    = 16;
   localparam int DEPTH = 4;

   logic          clock;
   logic          i_reset;
   logic [CW-1:0] i_counter;
   logic          i_event;
   logic          o_valid;
   logic          i_ready;
   logic [CW-1:0] o_timestamp;
   logic [2:0]    o_level;
   logic          o_overflow;
   logic          i_clear_overflow;

   int n_compared   = 0;
   int n_mismatched = 0;

   logic [CW-1:0] cnt;
   logic [CW-1:0] model_q[$];
   bit            model_prev;
   bit            model_ovf;

   event_timestamp_capture #(.COUNTER_WIDTH(CW), .FIFO_DEPTH(DEPTH)) dut (
      .i_clock          (clock),
      .i_reset          (i_reset),
      .i_counter        (i_counter),
      .i_event          (i_event),
      .o_valid          (o_valid),
      .i_ready          (i_ready),
      .o_timestamp      (o_timestamp),
      .o_level          (o_level),
      .o_overflow       (o_overflow),
      .i_clear_overflow (i_clear_overflow)
   );

   // Free-running clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Reference behaviour for one clock edge, using the inputs now applied.
   function automatic void model_step();
      bit ev;
      bit pop;
      bit drop;
      if (!i_reset) begin
         model_q.delete();
         model_prev = 1'b1;
         model_ovf  = 1'b0;
      end else begin
         ev   = i_event && !model_prev;
         pop  = (model_q.size() != 0) && i_ready;
         drop = 1'b0;
         if (pop) void'(model_q.pop_front());
         if (ev) begin
            if (model_q.size() < DEPTH) model_q.push_back(i_counter);
            else drop = 1'b1;
         end
         if (drop) model_ovf = 1'b1;
         else if (i_clear_overflow) model_ovf = 1'b0;
         model_prev = i_event;
      end
   endfunction

   task automatic compare_outputs();
      check_value("valid", {31'd0, o_valid}, {31'd0, model_q.size() != 0});
      check_value("level", {29'd0, o_level}, model_q.size());
      check_value("overflow", {31'd0, o_overflow}, {31'd0, model_ovf});
      if (model_q.size() != 0)
         check_value("head", {16'd0, o_timestamp}, {16'd0, model_q[0]});
   endtask

   task automatic set_counter(input logic [CW-1:0] v);
      cnt       = v;
      i_counter = v;
   endtask

   // Apply inputs, advance one edge, advance the counter, check outputs.
   task automatic cycle(input logic rst, input logic ev, input logic rdy, input logic clr);
      i_reset          = rst;
      i_event          = ev;
      i_ready          = rdy;
      i_clear_overflow = clr;
      model_step();
      @(posedge clock);
      #1;
      cnt       = cnt + 16'd1;
      i_counter = cnt;
      compare_outputs();
   endtask

   initial begin
      logic [CW-1:0] drain_exp [4];
      int ready_pct;
      drain_exp[0] = 16'h0022;
      drain_exp[1] = 16'h0024;
      drain_exp[2] = 16'h0026;
      drain_exp[3] = 16'h0040;

      i_reset = 1'b0; i_event = 1'b1; i_ready = 1'b0; i_clear_overflow = 1'b0;
      model_prev = 1'b1; model_ovf = 1'b0;
      set_counter(16'h0000);
      #1;

      // Reset with event already high, then release: no capture.
      repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check_value("reset_ts", {16'd0, o_timestamp}, 32'd0);
      repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check_value("release_level", {29'd0, o_level}, 32'd0);
      check_value("release_valid", {31'd0, o_valid}, 32'd0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);

      // Single capture at counter 0x0010.
      set_counter(16'h0010);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check_value("single_valid", {31'd0, o_valid}, 32'd1);
      check_value("single_ts", {16'd0, o_timestamp}, 32'h0010);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      check_value("single_popped", {31'd0, o_valid}, 32'd0);

      // Fill with consumer stalled: events at 0x20, 0x22, 0x24, 0x26.
      set_counter(16'h0020);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 1'b0);
         cycle(1'b1, 1'b0, 1'b0, 1'b0);
      end
      check_value("fill_level", {29'd0, o_level}, 32'd4);
      check_value("fill_ovf", {31'd0, o_overflow}, 32'd0);

      // Fifth event is dropped; clear coinciding with a drop loses.
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check_value("drop_ovf", {31'd0, o_overflow}, 32'd1);
      check_value("drop_level", {29'd0, o_level}, 32'd4);
      check_value("drop_head", {16'd0, o_timestamp}, 32'h0020);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      check_value("clear_vs_drop", {31'd0, o_overflow}, 32'd1);
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      check_value("clear_alone", {31'd0, o_overflow}, 32'd0);

      // Push and pop at full.
      set_counter(16'h0040);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check_value("pp_full_level", {29'd0, o_level}, 32'd4);
      check_value("pp_full_ovf", {31'd0, o_overflow}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         check_value("drain_order", {16'd0, o_timestamp}, {16'd0, drain_exp[i]});
         cycle(1'b1, 1'b0, 1'b1, 1'b0);
      end
      check_value("drained", {31'd0, o_valid}, 32'd0);

      // Counter wrap: events at 0xFFFF and 0x0001.
      set_counter(16'hFFFE);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check_value("wrap_level", {29'd0, o_level}, 32'd2);
      check_value("wrap_first", {16'd0, o_timestamp}, 32'hFFFF);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      check_value("wrap_second", {16'd0, o_timestamp}, 32'h0001);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check_value("pre_reset_level", {29'd0, o_level}, 32'd2);

      // Reset mid-operation with an event rising at the reset edge.
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check_value("midrst_valid", {31'd0, o_valid}, 32'd0);
      check_value("midrst_level", {29'd0, o_level}, 32'd0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check_value("post_rst_nocap", {29'd0, o_level}, 32'd0);

      // Randomized traffic with varying consumer readiness.
      ready_pct = 50;
      for (int i = 0; i < 4000; i++) begin
         if (i % 500 == 0) ready_pct = $urandom_range(0, 100);
         if ($urandom_range(0, 63) == 0) set_counter(16'($urandom));
         cycle(($urandom_range(0, 299) != 0),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 99) < ready_pct),
               ($urandom_range(0, 15) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/event_timestamp_capture.md
# event_timestamp_capture

Captures the value of the free-running `counter` on each rising edge of an event input. Captured values are buffered in a small first-word-fall-through FIFO and presented downstream over a valid/ready handshake. The block sits directly downstream of `counter` and takes its `o_counter` output as a timebase, turning raw event pulses into timestamped records for a consumer that may stall.

## Interface
- `COUNTER_WIDTH`, default 16: width of the incoming counter value and of each timestamp.
- `FIFO_DEPTH`, default 4: number of timestamp entries; must be a power of two, ≥ 2.
- `i_clock`  input  1: single clock; all logic on rising edge.
- `i_reset`  input  1: synchronous, active-low reset (asserted when 0).
- `i_counter`  input  COUNTER_WIDTH: timebase value from `counter.o_counter`, same clock domain.
- `i_event`  input  1: event level, already synchronous to `i_clock`; a 0→1 transition is one event.
- `o_valid`  output  1: FIFO head holds a timestamp.
- `i_ready`  input  1: consumer accepts head this cycle.
- `o_timestamp`  output  COUNTER_WIDTH: FIFO head value; valid only while `o_valid`=1.
- `o_level`  output  $clog2(FIFO_DEPTH)+1: number of stored entries, 0..FIFO_DEPTH.
- `o_overflow`  output  1: sticky; set when an event is dropped because the FIFO is full.
- `i_clear_overflow`  input  1: clears `o_overflow` for one cycle.

## Operation
- **Edge detect.** Register `event_q` holds the previous `i_event`. An event occurs in a cycle where `i_event`=1 and `event_q`=0.
- **Reset.** While `i_reset`=0, `event_q` is forced to 1. An event input already high when reset releases therefore produces no capture.
- **Capture.** On an event, the value of `i_counter` sampled at that same clock edge is the timestamp. There is no extra pipeline skew.
- **Push.** Accepted if the FIFO is not full, or if it is full and a pop occurs at the same edge.
- **Drop.** If an event arrives while the FIFO is full and no pop occurs at that edge, the event is dropped and `o_overflow` is set. FIFO contents are unchanged.
- **Pop.** Occurs when `o_valid`=1 and `i_ready`=1 at a clock edge. `i_ready` while `o_valid`=0 has no effect.
- **Ordering.** Strict FIFO order. A simultaneous push and pop leaves `o_level` unchanged, including at level 0 and at level FIFO_DEPTH.
- **Push into empty FIFO.** The new entry becomes the head directly; it is never popped in the same cycle it is written.
- **Overflow flag.** `o_overflow` stays set until `i_clear_overflow`=1. If a clear and a new drop occur at the same edge, the set wins and `o_overflow` stays 1.
- **Pointer arithmetic.** Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full/empty status comes from `o_level`, not from pointer equality.
- **Timestamp wrap.** Timestamps are raw counter values, with no extension. The consumer handles counter wrap (FFFF→0000 for width 16).
- **Reset values.** `o_valid`=0, `o_level`=0, `o_overflow`=0, pointers 0, `o_timestamp`=0. FIFO storage is not reset.
- **Reset mid-operation.** All stored entries are discarded at the reset edge. An event at that edge is ignored.

## Timing
- **Capture latency.** Event detected at edge k → `o_valid`=1 and `o_timestamp`=`i_counter`@k in the cycle after edge k. Latency is one cycle.
- **Level updates.** `o_level` changes in the cycle after the push or pop edge.
- **Throughput.** Events spaced 2 cycles apart (minimum for a 0→1→0→1 input) are all captured while not full. Sustained drain is one pop per cycle.
- **Output registering.** `o_valid`, `o_level` and `o_overflow` are registered. `o_timestamp` is registered or a registered-address read of storage; it must not combinationally depend on `i_ready`.
- **Hold under stall.** With `o_valid`=1 and `i_ready`=0, `o_timestamp` holds stable.

## Test plan
- **Reset release with event high.** Hold `i_event`=1 during reset, release reset, and keep the counter running. Required: no capture, `o_valid`=0, `o_level`=0.
- **Single capture.** Counter enabled and `i_ready`=1. Raise `i_event` at the edge where `i_counter`=0x0010. Required: next cycle `o_valid`=1 and `o_timestamp`=0x0010, then `o_valid`=0 after the pop.
- **Fill and stall.** `i_ready`=0 and FIFO_DEPTH=4. Apply 4 events at counter values 0x20, 0x22, 0x24, 0x26. Required: `o_level`=4 and `o_overflow`=0. Then raise `i_ready` and check values are popped in order 0x20, 0x22, 0x24, 0x26.
- **Overflow.** FIFO full with `i_ready`=0, apply a 5th event. Required: `o_overflow`=1, `o_level`=4, and contents unchanged. Next, pulse `i_clear_overflow` together with a 6th event while still full. Required: `o_overflow` stays 1. Then pulse the clear alone. Required: `o_overflow`=0.
- **Push and pop at full.** FIFO full, with `i_ready`=1 and an event in the same cycle at counter 0x0040. Required: `o_level` stays 4, no overflow, and 0x0040 emerges last.
- **Wrap and mid-operation reset.** Start the counter near 0xFFFE and apply events at 0xFFFF and 0x0001. Required: timestamps read 0xFFFF then 0x0001. Then assert reset with 2 entries stored. Required: `o_valid`=0 and `o_level`=0 the cycle after the reset edge.
